dual_hbridge_pwm_driver: RTL and testbench
==========================================

// Module: dual_hbridge_pwm_driver
// PURPOSE
//   Downstream stage of the direction-control FSMs: converts per-motor 2-bit duty codes and
//   FWD/BWD requests into H-bridge drive signals (PWM enable + IN1/IN2) for motors A and B.
//   Glitch-free duty updates, dead-time on direction reversal, immediate stop, illegal-request guard.
// PARAMETERS
//   PERIOD       4000  clocks per PWM period (25 kHz at 100 MHz); must be a multiple of 4, >= 8
//   DEAD_CYCLES  1000  all-off clocks inserted on FWD<->BWD reversal; >= 1
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   rst          in   1  synchronous, active-high reset
//   DutyCycleA   in   2  motor A duty code: 00=25% 01=50% 10=75% 11=100%
//   DutyCycleB   in   2  motor B duty code, same encoding
//   FWDA, BWDA   in   1  motor A forward / backward request
//   FWDB, BWDB   in   1  motor B forward / backward request
//   ENA, ENB     out  1  PWM enable to bridge A / B
//   IN1A, IN2A   out  1  bridge A direction (10=fwd, 01=bwd, 00=coast)
//   IN1B, IN2B   out  1  bridge B direction, same encoding
//   Fault        out  1  high while either channel sees FWD and BWD both set
// BEHAVIOUR
// - Reset: all outputs 0, cnt=0, both channel FSMs OFF, latched duty=00, dead counters 0.
// - Shared counter cnt: 0..PERIOD-1, +1 per clk, wraps to 0; "pend" = (cnt==PERIOD-1).
// - Request decode per channel (sampled every clk): FWD&~BWD=REQ_F, BWD&~FWD=REQ_B,
//   neither=REQ_OFF, both=REQ_BAD (treated as REQ_OFF; drives Fault).
// - Threshold thr = (PERIOD/4)*(duty_latched+1); width clog2(PERIOD)+1; code 11 -> thr=PERIOD.
// - Channel FSM (A and B identical, independent), states OFF, RUN, DEAD; dir reg F/B:
//     OFF : REQ_F/REQ_B and pend -> RUN, dir<=request, duty latched from input; else stay.
//     RUN : REQ_OFF/REQ_BAD -> OFF immediately (no waiting for pend);
//           request opposite to dir -> DEAD, dead_cnt<=DEAD_CYCLES-1;
//           same dir -> stay; duty re-latched only on pend (never mid-period).
//     DEAD: dead_cnt decrements each clk; at dead_cnt==0 -> OFF. Requests ignored in DEAD
//           (REQ_OFF does not shorten it). OFF then restarts at the next pend.
// - Outputs registered from current state/cnt (1-clk latency):
//     EN  <= (state==RUN) && (cnt < thr);  IN1 <= RUN && dir==F;  IN2 <= RUN && dir==B.
//   Entry on pend => first RUN clk has cnt=0, so EN rises the clk after, high thr clks/period.
//   100%: EN high continuously while RUN. IN1 and IN2 never high together (required invariant).
// - Fault <= REQ_BAD on A or B (registered, not sticky).
// - Duty change mid-period takes effect in the period starting after next pend; unchanged
//   duty within a period even if input toggles.
// - rst mid-operation: outputs drop to 0 on the clk after rst sampled high; cnt restarts at 0.
// - Start latency: REQ_F/B in OFF -> EN/IN high 1..PERIOD+1 clks later (aligned to period).
// - Stop latency: REQ_OFF in RUN -> EN, IN1, IN2 low 2 clks after request sampled.
// TESTING (bench PERIOD=8, DEAD_CYCLES=3)
// 1 Reset: rst=1 for 3 clks with FWDA=1 -> all outputs 0; after release, RUN only from next pend.
// 2 FWDA=1, DutyCycleA=01 -> IN1A=1 IN2A=0, ENA high 4 of every 8 clks; code 11 -> ENA stuck 1.
// 3 Change DutyCycleA 00->10 at cnt=3 -> current period keeps 2 high clks, next period 6.
// 4 FWDA->BWDA in RUN -> IN1A/IN2A/ENA all 0 for 3 clks DEAD, then OFF until pend, then IN2A=1.
// 5 FWDB=BWDB=1 while B running fwd -> Fault=1, B stops in 2 clks, A unaffected; clear -> Fault=0.
// 6 rst asserted during RUN with ENA high -> outputs 0 next clk; assert IN1x&IN2x never both 1.

Source files
------------

// File: rtl/dual_hbridge_pwm_driver.sv
// ---------------------------------------------------------------------------
// dual_hbridge_pwm_driver
//   Converts per-motor 2-bit duty codes and FWD/BWD requests into H-bridge
//   drive signals for two motors (A and B). A single free-running period
//   counter is shared by both channels, so both bridges switch in phase.
//   Each channel runs its own OFF/RUN/DEAD state machine:
//     - a start is always aligned to a period boundary,
//     - duty is re-latched only at period boundaries (glitch-free updates),
//     - a direction reversal forces DEAD_CYCLES all-off clocks,
//     - a stop or illegal request drops the drive immediately.
//
// Parameters
//   PERIOD       clocks per PWM period; multiple of 4, >= 8
//   DEAD_CYCLES  all-off clocks inserted on a FWD<->BWD reversal; >= 1
//
// Ports
//   clk                  system clock, all logic on posedge
//   rst                  synchronous active-high reset
//   DutyCycleA/B [1:0]   duty code 00=25% 01=50% 10=75% 11=100%
//   FWDA/BWDA, FWDB/BWDB forward / backward requests per motor
//   ENA, ENB             PWM enable to each bridge (registered)
//   IN1A/IN2A, IN1B/IN2B bridge direction: 10=fwd 01=bwd 00=coast (registered)
//   Fault                high while either channel has FWD and BWD both set
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// hbridge_channel
//   One motor channel: request decode, state machine, duty latch and the
//   registered bridge outputs. The period counter lives in the parent.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   cnt [CNT_W-1:0] shared period counter value
//   pend            high on the last clock of a period
//   duty [1:0]      duty code input (sampled only at period boundaries)
//   fwd, bwd        direction requests
//   en, in1, in2    registered bridge drive
//   bad             combinational: fwd and bwd both set this clock
// ---------------------------------------------------------------------------
module hbridge_channel #(
  parameter int PERIOD      = 4000,
  parameter int DEAD_CYCLES = 1000,
  parameter int CNT_W       = $clog2(PERIOD),
  parameter int THR_W       = CNT_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             pend,
  input  logic [1:0]       duty,
  input  logic             fwd,
  input  logic             bwd,
  output logic             en,
  output logic             in1,
  output logic             in2,
  output logic             bad
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_F   = 2'd1,
    REQ_B   = 2'd2,
    REQ_BAD = 2'd3
  } req_t;

  // A one-cycle dead time still needs a 1-bit counter.
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  // Compare thresholds for each duty code. Code 11 equals PERIOD, which no
  // counter value reaches, so the enable stays high for the whole period.
  localparam logic [THR_W-1:0] THR_25  = THR_W'(PERIOD / 4);
  localparam logic [THR_W-1:0] THR_50  = THR_W'(PERIOD / 2);
  localparam logic [THR_W-1:0] THR_75  = THR_W'((PERIOD / 4) * 3);
  localparam logic [THR_W-1:0] THR_100 = THR_W'(PERIOD);

  state_t             state;
  logic               dir_bwd;   // 0 = forward, 1 = backward
  logic [1:0]         duty_q;
  logic [DEAD_W-1:0]  dead_cnt;
  req_t               req;
  logic [THR_W-1:0]   thr;
  logic               req_opposite;

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    req = REQ_OFF;
    unique case ({fwd, bwd})
      2'b10:   req = REQ_F;
      2'b01:   req = REQ_B;
      2'b11:   req = REQ_BAD;
      default: req = REQ_OFF;
    endcase
  end

  always_comb begin
    thr = THR_25;
    unique case (duty_q)
      2'b00:   thr = THR_25;
      2'b01:   thr = THR_50;
      2'b10:   thr = THR_75;
      default: thr = THR_100;
    endcase
  end

  assign bad          = (req == REQ_BAD);
  assign req_opposite = dir_bwd ? (req == REQ_F) : (req == REQ_B);

  // State machine and registered outputs. Outputs are derived from the
  // state and counter as they stand before this edge, which gives the
  // one-clock output latency relative to state changes.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OFF;
      dir_bwd  <= 1'b0;
      duty_q   <= 2'b00;
      dead_cnt <= '0;
      en       <= 1'b0;
      in1      <= 1'b0;
      in2      <= 1'b0;
    end else begin
      en  <= (state == S_RUN) && ({1'b0, cnt} < thr);
      in1 <= (state == S_RUN) && !dir_bwd;
      in2 <= (state == S_RUN) && dir_bwd;

      unique case (state)
        S_OFF: begin
          // Starts are aligned so the first RUN clock sees cnt == 0.
          if (pend && (req == REQ_F || req == REQ_B)) begin
            state   <= S_RUN;
            dir_bwd <= (req == REQ_B);
            duty_q  <= duty;
          end
        end

        S_RUN: begin
          if (req == REQ_OFF || req == REQ_BAD) begin
            state <= S_OFF;
          end else if (req_opposite) begin
            state    <= S_DEAD;
            dead_cnt <= DEAD_LOAD;
          end else if (pend) begin
            // Same direction: only pick up a new duty between periods.
            duty_q <= duty;
          end
        end

        S_DEAD: begin
          // Requests are ignored here; dead time always runs to completion.
          if (dead_cnt == '0) begin
            state <= S_OFF;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end

        default: state <= S_OFF;
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top level: shared period counter, two channels and the fault flag.
// ---------------------------------------------------------------------------
module dual_hbridge_pwm_driver #(
  parameter int PERIOD      = 4000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] DutyCycleA,
  input  logic [1:0] DutyCycleB,
  input  logic       FWDA,
  input  logic       BWDA,
  input  logic       FWDB,
  input  logic       BWDB,
  output logic       ENA,
  output logic       ENB,
  output logic       IN1A,
  output logic       IN2A,
  output logic       IN1B,
  output logic       IN2B,
  output logic       Fault
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int THR_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             pend;
  logic             bad_a;
  logic             bad_b;

  assign pend = (cnt == CNT_LAST);

  // NOTE: the counter and flags are reset synchronously inside the clocked
  // block; there is no storage array here that would need to skip reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (pend) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered, not sticky: clears the clock after the illegal request goes.
  always_ff @(posedge clk) begin
    if (rst) begin
      Fault <= 1'b0;
    end else begin
      Fault <= bad_a | bad_b;
    end
  end

  hbridge_channel #(
    .PERIOD      (PERIOD),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W),
    .THR_W       (THR_W)
  ) u_chan_a (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .pend (pend),
    .duty (DutyCycleA),
    .fwd  (FWDA),
    .bwd  (BWDA),
    .en   (ENA),
    .in1  (IN1A),
    .in2  (IN2A),
    .bad  (bad_a)
  );

  hbridge_channel #(
    .PERIOD      (PERIOD),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W),
    .THR_W       (THR_W)
  ) u_chan_b (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .pend (pend),
    .duty (DutyCycleB),
    .fwd  (FWDB),
    .bwd  (BWDB),
    .en   (ENB),
    .in1  (IN1B),
    .in2  (IN2B),
    .bad  (bad_b)
  );

endmodule

// File: tb/tb_dual_hbridge_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_dual_hbridge_pwm_driver
//   Directed scenarios followed by randomized requests, duty codes and
//   occasional resets. Expected outputs come from a behavioural model that
//   tracks, per motor, the running direction (+1 / -1 / 0), the remaining
//   dead time and the latched duty, and derives the period phase from the
//   number of clocks since reset.
// ---------------------------------------------------------------------------
module tb_dual_hbridge_pwm_driver;

  localparam int P = 8;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] duty [2];
  logic       fwd  [2];
  logic       bwd  [2];

  logic ENA, ENB, IN1A, IN2A, IN1B, IN2B, Fault;

  always #5 clk = ~clk;

  dual_hbridge_pwm_driver #(
    .PERIOD      (P),
    .DEAD_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DutyCycleA (duty[0]),
    .DutyCycleB (duty[1]),
    .FWDA       (fwd[0]),
    .BWDA       (bwd[0]),
    .FWDB       (fwd[1]),
    .BWDB       (bwd[1]),
    .ENA        (ENA),
    .ENB        (ENB),
    .IN1A       (IN1A),
    .IN2A       (IN2A),
    .IN1B       (IN1B),
    .IN2B       (IN2B),
    .Fault      (Fault)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int t;                 // clocks since reset released (phase = t % P)
  int run_dir   [2];     // +1 forward, -1 backward, 0 not driving
  int dead_left [2];     // clocks of dead time still to go
  int duty_l    [2];     // duty code in force for the current period
  bit exp_en    [2];
  bit exp_in1   [2];
  bit exp_in2   [2];
  bit exp_fault;
  int en_hi     [2];     // enable-high clocks since last cleared

  function automatic int req_dir(logic f, logic b);
    if (f && !b) return 1;
    if (b && !f) return -1;
    return 0;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int  phase;
    bit  last;
    if (rst) begin
      t = 0;
      exp_fault = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        run_dir[ch] = 0; dead_left[ch] = 0; duty_l[ch] = 0;
        exp_en[ch] = 1'b0; exp_in1[ch] = 1'b0; exp_in2[ch] = 1'b0;
      end
      return;
    end
    phase = t % P;
    last  = (phase == P - 1);
    exp_fault = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      int r;
      r = req_dir(fwd[ch], bwd[ch]);
      if (fwd[ch] && bwd[ch]) exp_fault = 1'b1;
      exp_en[ch]  = (run_dir[ch] != 0) && (phase < (P / 4) * (duty_l[ch] + 1));
      exp_in1[ch] = (run_dir[ch] == 1);
      exp_in2[ch] = (run_dir[ch] == -1);
      if (dead_left[ch] > 0) begin
        dead_left[ch]--;
      end else if (run_dir[ch] == 0) begin
        if (r != 0 && last) begin
          run_dir[ch] = r;
          duty_l[ch]  = int'(duty[ch]);
        end
      end else if (r == 0) begin
        run_dir[ch] = 0;
      end else if (r == -run_dir[ch]) begin
        run_dir[ch]   = 0;
        dead_left[ch] = D;
      end else if (last) begin
        duty_l[ch] = int'(duty[ch]);
      end
    end
    t++;
  endtask

  // Called with inputs set just after a falling edge; returns at the next one.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("ENA",   ENA,   exp_en[0]);
    check("IN1A",  IN1A,  exp_in1[0]);
    check("IN2A",  IN2A,  exp_in2[0]);
    check("ENB",   ENB,   exp_en[1]);
    check("IN1B",  IN1B,  exp_in1[1]);
    check("IN2B",  IN2B,  exp_in2[1]);
    check("FAULT", Fault, exp_fault);
    check("EXCL_A", IN1A & IN2A, 1'b0);
    check("EXCL_B", IN1B & IN2B, 1'b0);
    en_hi[0] += int'(ENA);
    en_hi[1] += int'(ENB);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      duty[ch] = 2'b00; fwd[ch] = 1'b0; bwd[ch] = 1'b0;
      en_hi[ch] = 0;
    end
    rst = 1'b1;
    @(negedge clk);

    // 1: reset held with a forward request, then start aligned to a period
    fwd[0] = 1'b1; duty[0] = 2'b01;
    run(3);
    rst = 1'b0;
    run(2 * P);

    // 2: 50% duty, then 100%
    en_hi[0] = 0;
    run(P);
    check("ENA_DUTY50", en_hi[0], 4);
    check("IN1A_FWD", IN1A, 1'b1);
    duty[0] = 2'b11;
    run(2 * P);
    en_hi[0] = 0;
    run(P);
    check("ENA_DUTY100", en_hi[0], P);

    // 3: duty change mid-period only takes effect from the next period
    duty[0] = 2'b00;
    run(2 * P);
    for (int k = 0; k < P && (t % P) != 3; k++) cycle();
    duty[0] = 2'b10;
    en_hi[0] = 0;
    run(5);
    check("DUTY_KEEP", en_hi[0], 0);
    en_hi[0] = 0;
    run(P);
    check("DUTY_NEXT", en_hi[0], 6);

    // 4: reversal goes through dead time, then restarts backward
    fwd[0] = 1'b0; bwd[0] = 1'b1;
    run(2 * P);
    check("IN2A_AFTER_REV", IN2A, 1'b1);
    check("IN1A_AFTER_REV", IN1A, 1'b0);

    // 5: illegal request on B while A keeps running
    fwd[1] = 1'b1; duty[1] = 2'b01;
    run(2 * P);
    bwd[1] = 1'b1;
    run(3);
    check("FAULT_SET", Fault, 1'b1);
    check("IN1B_STOP", IN1B, 1'b0);
    check("IN2A_HOLD", IN2A, 1'b1);
    fwd[1] = 1'b0; bwd[1] = 1'b0;
    run(1);
    check("FAULT_CLR", Fault, 1'b0);

    // 6: reset while the enable is high
    for (int k = 0; k < 2 * P && !ENA; k++) cycle();
    check("ENA_SEEN", ENA, 1'b1);
    rst = 1'b1;
    run(1);
    check("ENA_RST", ENA, 1'b0);
    check("IN2A_RST", IN2A, 1'b0);
    rst = 1'b0;

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 15) == 0) begin
          logic [1:0] fb;
          fb = 2'($urandom_range(0, 3));
          fwd[ch] = fb[1];
          bwd[ch] = fb[0];
        end
        if ($urandom_range(0, 7) == 0) duty[ch] = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
